// File: rtl/tile_border_scanner.sv
// Tile border read sequencer: walks the 4*TILE-4 border pixels of a tile, issues one
// frame-buffer read per pixel and reports each value plus a running sum and threshold count.
module tile_border_scanner #(
    parameter int FRAME_W = 320,
    parameter int TILE    = 8,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] thresh,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              edge_valid,
    output logic [DATA_W-1:0] edge_value,
    output logic [4:0]        edge_index,
    output logic [DATA_W+4:0] edge_sum,
    output logic [4:0]        edge_count,
    output logic              busy,
    output logic              done
);
    localparam int NB      = 4 * TILE - 4;
    localparam int OFF_MIN = $clog2(TILE * FRAME_W);
    localparam int OFF_W   = (OFF_MIN > 12) ? OFF_MIN : 12;
    localparam int SUM_W   = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 1;
    localparam int WAIT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ACC_W   = DATA_W + 5;

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    state_t            state;
    logic [4:0]        idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] thresh_q;
    logic [4:0]        next_idx;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] next_addr;
    logic              last_wait;

    // Border index -> tile offset: top row, then left/right pairs of middle rows, then bottom row.
    function automatic logic [OFF_W-1:0] border_offset(input logic [4:0] i);
        int n, k, x, y;
        n = int'(i);
        if (n < TILE) begin
            y = 0;
            x = n;
        end else if (n < NB - TILE) begin
            k = n - TILE;
            y = 1 + k / 2;
            x = (k % 2 == 1) ? TILE - 1 : 0;
        end else begin
            y = TILE - 1;
            x = n - (NB - TILE);
        end
        return OFF_W'(y * FRAME_W + x);
    endfunction

    // The address of the next strobe is prepared one cycle ahead so rd_addr can be registered.
    always_comb begin
        next_idx  = (state == IDLE) ? 5'd0 : idx + 5'd1;
        next_base = (state == IDLE) ? base_addr : base_q;
        next_addr = ADDR_W'(SUM_W'(next_base) + SUM_W'(border_offset(next_idx)));
        last_wait = (state == WAIT) && (wait_cnt == WAIT_W'(RD_LAT - 1));
    end

    // NOTE: every register here uses <= so all reads in this block see pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= 5'd0;
            wait_cnt   <= '0;
            base_q     <= '0;
            thresh_q   <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            edge_valid <= 1'b0;
            edge_value <= '0;
            edge_index <= 5'd0;
            edge_sum   <= '0;
            edge_count <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_en      <= 1'b0;
            edge_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        thresh_q   <= thresh;
                        edge_sum   <= '0;
                        edge_count <= 5'd0;
                        idx        <= next_idx;
                        rd_en      <= 1'b1;
                        rd_addr    <= next_addr;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (last_wait) begin
                        edge_value <= rd_data;
                        edge_index <= idx;
                        edge_valid <= 1'b1;
                        edge_sum   <= edge_sum + ACC_W'(rd_data);
                        edge_count <= edge_count + {4'd0, (rd_data >= thresh_q)};
                        if (idx == 5'(NB - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx     <= next_idx;
                            rd_en   <= 1'b1;
                            rd_addr <= next_addr;
                            state   <= READ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_border_scanner.sv
// Scoreboard bench for tile_border_scanner: one instance at read latency 1 with a random
// frame-buffer model, one at read latency 3 whose memory answers only in the valid cycle.
`timescale 1ns/1ps
module tb_tile_border_scanner;
    localparam int FRAME_W = 320;
    localparam int TILE    = 8;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 8;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 3;
    localparam int AMOD    = 1 << ADDR_W;

    typedef struct { int idx; int addr; } rd_exp_t;
    typedef struct { int idx; int val; int sum; } edge_exp_t;
    typedef struct { int sum; int cnt; int t0; } done_exp_t;

    logic clock = 1'b0;
    logic resetn;
    logic start, start_b;
    logic [ADDR_W-1:0] base_addr, base_addr_b;
    logic [DATA_W-1:0] thresh, thresh_b;
    logic rd_en, rd_en_b;
    logic [ADDR_W-1:0] rd_addr, rd_addr_b;
    logic [DATA_W-1:0] rd_data, rd_data_b;
    logic edge_valid, edge_valid_b;
    logic [DATA_W-1:0] edge_value, edge_value_b;
    logic [4:0] edge_index, edge_index_b;
    logic [DATA_W+4:0] edge_sum, edge_sum_b;
    logic [4:0] edge_count, edge_count_b;
    logic busy, busy_b, done, done_b;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit aborting = 1'b0;
    int done_seen = 0, rd_strobes = 0, last_rd_cyc = 0;
    int done_b_seen = 0, b_rd_k = 0, b_edge_k = 0, b_base = 0, b_t0 = 0;
    int mem_mode = 0, mem_seed = 0;
    int border_off[$];
    rd_exp_t   exp_rd[$];
    edge_exp_t exp_edge[$];
    done_exp_t exp_done[$];
    rd_exp_t   mon_r;
    edge_exp_t mon_e;
    done_exp_t mon_d;
    bit ha_en [0:LAT_A];
    int ha_addr [0:LAT_A];
    bit hb_en [0:LAT_B];

    tile_border_scanner #(.FRAME_W(FRAME_W), .TILE(TILE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT_A)) u_dut_a (
        .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr), .thresh(thresh),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .edge_valid(edge_valid), .edge_value(edge_value), .edge_index(edge_index),
        .edge_sum(edge_sum), .edge_count(edge_count), .busy(busy), .done(done));

    tile_border_scanner #(.FRAME_W(FRAME_W), .TILE(TILE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT_B)) u_dut_b (
        .clock(clock), .resetn(resetn), .start(start_b), .base_addr(base_addr_b), .thresh(thresh_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .edge_valid(edge_valid_b), .edge_value(edge_value_b), .edge_index(edge_index_b),
        .edge_sum(edge_sum_b), .edge_count(edge_count_b), .busy(busy_b), .done(done_b));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_val(input int mode, input int a, input int seed);
        case (mode)
            0:       return 8'd1;
            1:       return 8'(a);
            default: return 8'((a * 131) ^ seed ^ (a >>> 5));
        endcase
    endfunction

    // Frame buffer for instance A: answers LAT_A cycles after the strobe, garbage otherwise.
    always @(negedge clock) begin
        for (int i = LAT_A; i > 0; i--) begin
            ha_en[i]   = ha_en[i-1];
            ha_addr[i] = ha_addr[i-1];
        end
        ha_en[0]   = (rd_en === 1'b1);
        ha_addr[0] = int'(rd_addr);
        rd_data = ha_en[LAT_A] ? mem_val(mem_mode, ha_addr[LAT_A], mem_seed) : 8'($urandom);
    end

    // Frame buffer for instance B: 0xFF only in the cycle the read is due, else 0x00.
    always @(negedge clock) begin
        for (int i = LAT_B; i > 0; i--) hb_en[i] = hb_en[i-1];
        hb_en[0] = (rd_en_b === 1'b1);
        rd_data_b = hb_en[LAT_B] ? 8'hFF : 8'h00;
    end

    // Monitor A: pops the scoreboard whenever the DUT strobes a read, reports an edge or finishes.
    always @(negedge clock) begin
        if (resetn && !aborting) begin
            if (rd_en) begin
                rd_strobes++;
                check("rd_expected", int'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) begin
                    mon_r = exp_rd.pop_front();
                    check($sformatf("rd_addr[%0d]", mon_r.idx), int'(rd_addr), mon_r.addr);
                    if (mon_r.idx > 0) check("rd_spacing", cyc - last_rd_cyc, 1 + LAT_A);
                    last_rd_cyc = cyc;
                end
            end
            if (edge_valid) begin
                check("edge_expected", int'(exp_edge.size() > 0), 1);
                if (exp_edge.size() > 0) begin
                    mon_e = exp_edge.pop_front();
                    check("edge_index", int'(edge_index), mon_e.idx);
                    check($sformatf("edge_value[%0d]", mon_e.idx), int'(edge_value), mon_e.val);
                    check($sformatf("edge_sum_run[%0d]", mon_e.idx), int'(edge_sum), mon_e.sum);
                end
            end
            if (done) begin
                done_seen++;
                check("done_expected", int'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) begin
                    mon_d = exp_done.pop_front();
                    check("done_sum", int'(edge_sum), mon_d.sum);
                    check("done_count", int'(edge_count), mon_d.cnt);
                    // edges counted from the accepting edge through the edge that ends the done cycle
                    check("done_latency", cyc - mon_d.t0 + 2, 2 + border_off.size() * (1 + LAT_A));
                    check("done_busy", int'(busy), 0);
                end
            end
        end
    end

    // Monitor B: every captured value must be the in-window 0xFF.
    always @(negedge clock) begin
        if (resetn && !aborting) begin
            if (rd_en_b && b_rd_k < border_off.size()) begin
                check("b_rd_addr", int'(rd_addr_b), (b_base + border_off[b_rd_k]) % AMOD);
                b_rd_k++;
            end
            if (edge_valid_b) begin
                check("b_edge_value", int'(edge_value_b), 255);
                check("b_edge_index", int'(edge_index_b), b_edge_k);
                b_edge_k++;
            end
            if (done_b) begin
                done_b_seen++;
                check("b_done_sum", int'(edge_sum_b), border_off.size() * 255);
                check("b_done_count", int'(edge_count_b), border_off.size());
                check("b_edges_seen", b_edge_k, border_off.size());
                check("b_done_latency", cyc - b_t0 + 2, 2 + border_off.size() * (1 + LAT_B));
                b_rd_k   = 0;
                b_edge_k = 0;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_edge_valid"}, int'(edge_valid), 0);
        check({tag, "_edge_value"}, int'(edge_value), 0);
        check({tag, "_edge_index"}, int'(edge_index), 0);
        check({tag, "_edge_sum"}, int'(edge_sum), 0);
        check({tag, "_edge_count"}, int'(edge_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic issue_scan(input int base, input int th, input int mode, output int t0, output int sum, output int cnt);
        rd_exp_t r;
        edge_exp_t e;
        done_exp_t d;
        int a, v;
        mem_mode  = mode;
        mem_seed  = int'($urandom);
        base_addr = ADDR_W'(base);
        thresh    = DATA_W'(th);
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        t0 = cyc;
        sum = 0;
        cnt = 0;
        foreach (border_off[i]) begin
            a = (base + border_off[i]) % AMOD;
            v = int'(mem_val(mode, a, mem_seed));
            sum += v;
            if (v >= th) cnt++;
            r.idx = i; r.addr = a;
            exp_rd.push_back(r);
            e.idx = i; e.val = v; e.sum = sum;
            exp_edge.push_back(e);
        end
        d.sum = sum; d.cnt = cnt; d.t0 = t0;
        exp_done.push_back(d);
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_seen == n0 && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        check("done_arrived", done_seen - n0, 1);
        if (done_seen == n0) begin
            exp_rd.delete();
            exp_edge.delete();
            exp_done.delete();
        end
    endtask

    task automatic run_scan(input int base, input int th, input int mode);
        int n0, t0, sum, cnt;
        n0 = done_seen;
        issue_scan(base, th, mode, t0, sum, cnt);
        wait_done(n0);
        repeat (3) begin @(posedge clock); #1; end
        check("hold_sum", int'(edge_sum), sum);
        check("hold_count", int'(edge_count), cnt);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int n0, s0, t0, sum, cnt, k;
        for (int y = 0; y < TILE; y++)
            for (int x = 0; x < TILE; x++)
                if (y == 0 || y == TILE - 1 || x == 0 || x == TILE - 1)
                    border_off.push_back(y * FRAME_W + x);

        resetn = 1'b0;
        start = 1'b0; base_addr = '0; thresh = '0;
        start_b = 1'b0; base_addr_b = '0; thresh_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        check("reset_busy_b", int'(busy_b), 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Read latency 3: only correctly-timed samples see 0xFF.
        b_base = int'($urandom_range(0, AMOD - 1));
        base_addr_b = ADDR_W'(b_base);
        thresh_b = 8'hFF;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        b_t0 = cyc;
        n0 = done_b_seen;
        k = 0;
        while (done_b_seen == n0 && k < 300) begin @(posedge clock); #1; k++; end
        check("b_done_arrived", done_b_seen - n0, 1);
        check("b_busy_after", int'(busy_b), 0);

        run_scan(0, 1, 0);
        run_scan(1000, 8'h80, 1);
        run_scan(AMOD - 2, int'($urandom_range(0, 255)), 2);
        repeat (3) run_scan(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, 255)), 2);
        run_scan(int'($urandom_range(0, AMOD - 1)), 0, 2);
        run_scan(int'($urandom_range(0, AMOD - 1)), 255, 2);

        // Starts mid-scan and on the done cycle must be dropped.
        n0 = done_seen;
        s0 = rd_strobes;
        issue_scan(4321, 60, 2, t0, sum, cnt);
        while (cyc < t0 + 5) begin @(posedge clock); #1; end
        start = 1'b1; @(posedge clock); #1; start = 1'b0;
        while (cyc < t0 + 30) begin @(posedge clock); #1; end
        start = 1'b1; @(posedge clock); #1; start = 1'b0;
        while (cyc < t0 + 2 + border_off.size() * (1 + LAT_A) - 2) begin @(posedge clock); #1; end
        start = 1'b1; @(posedge clock); #1; start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        check("ignored_start_dones", done_seen - n0, 1);
        check("ignored_start_strobes", rd_strobes - s0, border_off.size());
        check("ignored_start_busy", int'(busy), 0);

        // Reset in the middle of a scan aborts without a done pulse.
        n0 = done_seen;
        issue_scan(5000, 100, 2, t0, sum, cnt);
        while (cyc < t0 + 20) begin @(posedge clock); #1; end
        aborting = 1'b1;
        resetn = 1'b0;
        @(posedge clock); #1;
        check_zero("abort");
        exp_rd.delete();
        exp_edge.delete();
        exp_done.delete();
        resetn = 1'b1;
        aborting = 1'b0;
        repeat (70) begin @(posedge clock); #1; end
        check("abort_no_done", done_seen - n0, 0);
        run_scan(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, 255)), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_border_scanner.md
Name: tile_border_scanner

Overview:
- Sequences frame-buffer reads of the 28 border pixels of an 8x8 tile so the edge-detection datapath can use them.
- On `start`, walks border offsets in fixed order, issues one read per pixel and captures each returned value.
- Reports each captured value, a running sum, and a count of pixels at or above a threshold.
- Sits between the frame-buffer read port and the edge-value datapath; replaces free-running per-pixel load strobes with a start/busy/done transaction.

Parameters:
- FRAME_W, 320, frame row pitch in pixels (offset of one tile row)
- TILE, 8, tile edge length; border count NB = 4*TILE-4 (28 at default)
- ADDR_W, 17, frame-buffer address width (320x240 fits)
- DATA_W, 8, pixel width
- RD_LAT, 1, read latency in cycles, >=1

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE
- base_addr  in  ADDR_W  address of tile top-left pixel; latched on accepted start
- thresh  in  DATA_W  edge threshold; latched on accepted start
- rd_en  out  1  read strobe to frame buffer
- rd_addr  out  ADDR_W  read address, valid when rd_en=1
- rd_data  in  DATA_W  read data, valid exactly RD_LAT cycles after the rd_en cycle
- edge_valid  out  1  one-cycle pulse: edge_value/edge_index valid
- edge_value  out  DATA_W  captured border pixel
- edge_index  out  5  border index 0..NB-1 of edge_value
- edge_sum  out  DATA_W+5  sum of captured pixels this scan
- edge_count  out  5  number of captured pixels >= thresh
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at scan completion

Behaviour:
- Reset (resetn=0 at a clock edge), effective next cycle:
  - state=IDLE, idx=0.
  - rd_en, rd_addr, edge_valid, edge_value, edge_index, edge_sum, edge_count, busy, done all 0.
  - Reset mid-scan aborts immediately; no done pulse.
- Border order (x,y within tile), idx 0..NB-1:
  - Top row: y=0, x=0..TILE-1.
  - Middle rows y=1..TILE-2: left pixel (x=0), then right pixel (x=TILE-1).
  - Bottom row: y=TILE-1, x=0..TILE-1.
  - Offset = y*FRAME_W + x.
  - Defaults give offsets 0..7, 320, 327, 640, 647, 960, 967, 1280, 1287, 1600, 1607, 1920, 1927, 2240..2247.
  - Offset register is at least 12 bits; no truncation.
- rd_addr = (latched base + offset) mod 2^ADDR_W; wrap-around is silent.
- FSM:
  - IDLE: busy=0. start=1 latches base_addr and thresh, clears sum, count and idx, and goes to READ.
  - READ: one cycle; rd_en=1, rd_addr per idx. Goes to WAIT.
  - WAIT: RD_LAT cycles, tracked by a wait counter. In the last WAIT cycle:
    - rd_data is sampled;
    - edge_value <= rd_data and edge_index <= idx, with edge_valid pulsed the following cycle;
    - edge_sum += rd_data;
    - edge_count += (rd_data >= thresh), unsigned compare.
    - Then: if idx==NB-1 go to DONE, else idx++ and go to READ.
  - DONE: one cycle; done=1, busy=0. Next state IDLE.
- Timing:
  - Per pixel: 1+RD_LAT cycles.
  - done is high exactly 2+NB*(1+RD_LAT) cycles after the start-accept edge: 58 at defaults, 114 for RD_LAT=3.
  - Last edge_valid coincides with the DONE cycle.
- Start handling: start during READ, WAIT or DONE is ignored; it is not queued.
- Outputs after done: edge_sum, edge_count and edge_value hold until the next accepted start.
- Arithmetic: sum max NB*(2^DATA_W-1) = 7140 at defaults, which fits DATA_W+5 bits; no overflow handling needed.

Test Plan:
- Memory mem[a]=1, base=0, thresh=1, RD_LAT=1 -> rd_addr sequence 0..7, 320, 327, ..., 1927, 2240..2247 (28 strobes, one every 2 cycles); edge_sum=28, edge_count=28; done 58 cycles after start; busy low afterwards.
- Memory mem[a]=a[7:0], base=1000, thresh=0x80 -> edge_index 0..27 in order; edge_sum and edge_count match the scoreboard; first rd_addr=1000, last rd_addr=3247.
- RD_LAT=3, memory returns 0xFF only in the correct cycle and 0x00 otherwise -> every edge_value=0xFF, edge_sum=7140; done at 114 cycles.
- base=2^17-2 -> rd_addr 131070, 131071, 0, 1, ... (silent wrap).
- start re-pulsed at cycles 5 and 30 of a scan -> ignored; exactly one done; a start pulsed on the done cycle is also ignored.
- resetn low at cycle 20 of a scan -> next cycle all outputs 0, no done; a fresh start then completes a normal 58-cycle scan.
